issue_scheduler: RTL and testbench

//  Dual-issue scheduler between the instruction-memory pair output and the two decode lanes.

---
 rtl/issue_scheduler_if.sv | 36 +++
 rtl/issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Signal bundle between fetch, the dual-issue scheduler and the decode lanes.
interface issue_scheduler_if #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int CNT_W    = 16
);
  logic                is_i_valid;
  logic [IWIDTH-1:0]   is_i_instr_1;
  logic [IWIDTH-1:0]   is_i_instr_2;
  logic [PC_WIDTH-1:0] is_i_pc_1;
  logic                is_o_ready;
  logic                is_i_ex_ready;
  logic                is_i_flush;
  logic                is_o_valid_1;
  logic                is_o_valid_2;
  logic [IWIDTH-1:0]   is_o_instr_1;
  logic [IWIDTH-1:0]   is_o_instr_2;
  logic [PC_WIDTH-1:0] is_o_pc_1;
  logic [PC_WIDTH-1:0] is_o_pc_2;
  logic                is_o_split;
  logic [CNT_W-1:0]    is_o_dual_cnt;

  // scheduler side
  modport slave (
    input  is_i_valid, is_i_instr_1, is_i_instr_2, is_i_pc_1, is_i_ex_ready, is_i_flush,
    output is_o_ready, is_o_valid_1, is_o_valid_2, is_o_instr_1, is_o_instr_2,
           is_o_pc_1, is_o_pc_2, is_o_split, is_o_dual_cnt
  );

  // fetch / backend side
  modport master (
    output is_i_valid, is_i_instr_1, is_i_instr_2, is_i_pc_1, is_i_ex_ready, is_i_flush,
    input  is_o_ready, is_o_valid_1, is_o_valid_2, is_o_instr_1, is_o_instr_2,
           is_o_pc_1, is_o_pc_2, is_o_split, is_o_dual_cnt
  );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: buffers one fetched pair, issues it together or split
// over two cycles, inserts a one-cycle bubble on load-use, flushes on redirect.
module issue_scheduler #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int CNT_W    = 16
) (
  input logic              is_clk,
  input logic              is_rst,
  issue_scheduler_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, SECOND} state_t;

  typedef struct packed {
    logic [4:0] dst;     // 0 means no destination
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_src;  // rt is read as a source
    logic       mem;
    logic       ctrl;
    logic       load;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    op       = ins[31:26];
    d        = '0;
    d.rs     = ins[25:21];
    d.rt     = ins[20:16];
    if (op == 6'd0)                                    d.dst = ins[15:11];
    else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)   d.dst = ins[20:16];
    d.rt_src = (op == 6'd0) || (op[5:3] == 3'b101) || (op == 6'd4) || (op == 6'd5);
    d.mem    = (op[5:4] == 2'b10);
    d.ctrl   = (op == 6'd2) || (op == 6'd3) || (op == 6'd4) || (op == 6'd5);
    d.load   = (op[5:3] == 3'b100);
    return d;
  endfunction

  // $0 is never a real dependency
  function automatic logic reads(input dec_t d, input logic [4:0] r);
    return (r != 5'd0) && ((d.rs == r) || (d.rt_src && (d.rt == r)));
  endfunction

  state_t              state, state_n;
  logic [IWIDTH-1:0]   i1_q, i2_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                ll_vld;
  logic [4:0]          ll_rt;
  logic [CNT_W-1:0]    cnt_q;

  dec_t       d1, d2;
  logic       pair_haz;
  logic       offer_1, offer_2, sel2, split, lu;
  logic       valid_1, valid_2, xfer, last_xfer, ready, accept;
  logic [4:0] ld_rt_n;

  assign d1 = decode(i1_q[31:0]);
  assign d2 = decode(i2_q[31:0]);

  // RAW, WAW, single memory port, branch unit only in lane 1
  assign pair_haz = reads(d2, d1.dst) ||
                    ((d1.dst != 5'd0) && (d1.dst == d2.dst)) ||
                    (d1.mem && d2.mem) || d2.ctrl;

  // what the buffered state offers this cycle, and whether it hits last_load
  always_comb begin
    offer_1 = 1'b0;
    offer_2 = 1'b0;
    sel2    = 1'b0;
    split   = 1'b0;
    lu      = 1'b0;
    case (state)
      FULL: begin
        offer_1 = 1'b1;
        offer_2 = ~pair_haz;
        split   = pair_haz;
        lu      = ll_vld & (reads(d1, ll_rt) | (~pair_haz & reads(d2, ll_rt)));
      end
      SECOND: begin
        offer_1 = 1'b1;
        sel2    = 1'b1;
        split   = 1'b1;
        lu      = ll_vld & reads(d2, ll_rt);
      end
      default: ;
    endcase
  end

  assign valid_1   = offer_1 & ~lu;
  assign valid_2   = offer_2 & ~lu;
  assign xfer      = valid_1 & bus.is_i_ex_ready;
  // the buffer frees up when its final instruction leaves
  assign last_xfer = xfer & ((state == SECOND) | ~pair_haz);
  assign ready     = is_rst & ~bus.is_i_flush & ((state == EMPTY) | last_xfer);
  assign accept    = bus.is_i_valid & ready;

  // next state; flush wins over everything
  always_comb begin
    state_n = state;
    if (bus.is_i_flush) state_n = EMPTY;
    else begin
      case (state)
        EMPTY:   if (accept) state_n = FULL;
        FULL:    if (xfer) state_n = pair_haz ? SECOND : (accept ? FULL : EMPTY);
        SECOND:  if (xfer) state_n = accept ? FULL : EMPTY;
        default: state_n = EMPTY;
      endcase
    end
  end

  // destination of a load leaving this cycle (0 when none)
  always_comb begin
    ld_rt_n = 5'd0;
    if (xfer) begin
      if (sel2) begin
        if (d2.load) ld_rt_n = d2.dst;
      end else if (d1.load) ld_rt_n = d1.dst;
      else if (valid_2 && d2.load) ld_rt_n = d2.dst;
    end
  end

  // state, pair buffer, last-load tracker and dual-issue counter
  always_ff @(posedge is_clk or negedge is_rst) begin
    if (!is_rst) begin
      state  <= EMPTY;
      i1_q   <= '0;
      i2_q   <= '0;
      pc_q   <= '0;
      ll_vld <= 1'b0;
      ll_rt  <= 5'd0;
      cnt_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        i1_q <= bus.is_i_instr_1;
        i2_q <= bus.is_i_instr_2;
        pc_q <= bus.is_i_pc_1;
      end
      if (bus.is_i_flush) begin
        ll_vld <= 1'b0;
        ll_rt  <= 5'd0;
      end else if (bus.is_i_ex_ready) begin
        ll_vld <= (ld_rt_n != 5'd0);
        ll_rt  <= ld_rt_n;
      end
      if (!bus.is_i_flush && xfer && valid_2 && !(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.is_o_ready    = ready;
  assign bus.is_o_valid_1  = valid_1;
  assign bus.is_o_valid_2  = valid_2;
  assign bus.is_o_instr_1  = valid_1 ? (sel2 ? i2_q : i1_q) : '0;
  assign bus.is_o_pc_1     = valid_1 ? (sel2 ? pc_q + PC_WIDTH'(4) : pc_q) : '0;
  assign bus.is_o_instr_2  = valid_2 ? i2_q : '0;
  assign bus.is_o_pc_2     = valid_2 ? pc_q + PC_WIDTH'(4) : '0;
  assign bus.is_o_split    = split;
  assign bus.is_o_dual_cnt = cnt_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, with an
// issue-group scoreboard built from the pairing / load-use rules.
module tb_issue_scheduler;
  localparam int CW = 4;  // narrow counter so saturation is reached

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scheduler_if #(.IWIDTH(32), .PC_WIDTH(32), .CNT_W(CW)) bus ();
  issue_scheduler #(.IWIDTH(32), .PC_WIDTH(32), .CNT_W(CW)) dut (
    .is_clk(clk), .is_rst(rst_n), .bus(bus.slave)
  );

  typedef struct {
    bit          two;
    logic [31:0] i1, i2, pc1, pc2;
    bit          split;
  } grp_t;

  grp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [CW-1:0] cnt_m;
  logic [4:0]   prev_ld;
  bit           hold_vld;
  logic [130:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference rules ----
  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'd0) return ins[15:11];
    if (op[5:3] == 3'b001 || op[5:3] == 3'b100) return ins[20:16];
    return 5'd0;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op;
    op = ins[31:26];
    if (r == 5'd0) return 1'b0;
    if (ins[25:21] == r) return 1'b1;
    if (op == 6'd0 || op[5:3] == 3'b101 || op == 6'd4 || op == 6'd5) return ins[20:16] == r;
    return 1'b0;
  endfunction

  function automatic bit hazard(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] da, db;
    logic [5:0] ob;
    da = dest_of(a);
    db = dest_of(b);
    ob = b[31:26];
    if (reads_reg(b, da)) return 1'b1;
    if (da != 5'd0 && da == db) return 1'b1;
    if (a[31:30] == 2'b10 && b[31:30] == 2'b10) return 1'b1;
    if (ob == 6'd2 || ob == 6'd3 || ob == 6'd4 || ob == 6'd5) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit grp_reads(input grp_t g, input logic [4:0] r);
    return reads_reg(g.i1, r) || (g.two && reads_reg(g.i2, r));
  endfunction

  function automatic logic [4:0] grp_load(input grp_t g);
    if (g.i1[31:29] == 3'b100) return dest_of(g.i1);
    if (g.two && g.i2[31:29] == 3'b100) return dest_of(g.i2);
    return 5'd0;
  endfunction

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    grp_t g;
    if (hazard(a, b)) begin
      g = '{1'b0, a, 32'd0, pc, 32'd0, 1'b1};
      q.push_back(g);
      g = '{1'b0, b, 32'd0, pc + 32'd4, 32'd0, 1'b1};
      q.push_back(g);
    end else begin
      g = '{1'b1, a, b, pc, pc + 32'd4, 1'b0};
      q.push_back(g);
    end
  endtask

  function automatic logic [130:0] cur_snap();
    return {bus.is_o_valid_1, bus.is_o_valid_2, bus.is_o_split, bus.is_o_instr_1,
            bus.is_o_instr_2, bus.is_o_pc_1, bus.is_o_pc_2};
  endfunction

  // ---- monitor / scoreboard ----
  initial begin
    grp_t g;
    int   pend;
    bit   xfer;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        cnt_m    = '0;
        prev_ld  = 5'd0;
        hold_vld = 1'b0;
        continue;
      end
      xfer = bus.is_o_valid_1 && bus.is_i_ex_ready && !bus.is_i_flush;
      pend = q.size();
      chk("v2_without_v1", 64'(bus.is_o_valid_2 & ~bus.is_o_valid_1), 64'd0);
      chk("dual_cnt", 64'(bus.is_o_dual_cnt), 64'(cnt_m));
      if (hold_vld) chk("hold_stable", 64'(cur_snap() == snap), 64'd1);
      hold_vld = bus.is_o_valid_1 && !bus.is_i_ex_ready && !bus.is_i_flush;
      snap     = cur_snap();
      if (xfer) begin
        if (pend == 0) chk("spurious_issue", 64'(bus.is_o_instr_1), 64'hDEAD_0000_0000);
        else begin
          g = q.pop_front();
          chk("lane2_valid", 64'(bus.is_o_valid_2), 64'(g.two));
          chk("instr_1", 64'(bus.is_o_instr_1), 64'(g.i1));
          chk("pc_1", 64'(bus.is_o_pc_1), 64'(g.pc1));
          if (g.two) begin
            chk("instr_2", 64'(bus.is_o_instr_2), 64'(g.i2));
            chk("pc_2", 64'(bus.is_o_pc_2), 64'(g.pc2));
          end
          chk("split", 64'(bus.is_o_split), 64'(g.split));
          chk("load_use_issue", 64'(grp_reads(g, prev_ld)), 64'd0);
          if (g.two && cnt_m != '1) cnt_m = cnt_m + 1'b1;
        end
      end else if (pend > 0 && bus.is_i_ex_ready && !bus.is_i_flush)
        chk("bubble_reason", 64'(grp_reads(q[0], prev_ld)), 64'd1);
      if (bus.is_i_flush) begin
        chk("ready_in_flush", 64'(bus.is_o_ready), 64'd0);
        q.delete();
        prev_ld = 5'd0;
      end else begin
        chk("ready", 64'(bus.is_o_ready), 64'(q.size() == 0));
        if (bus.is_i_ex_ready) prev_ld = (xfer && pend > 0) ? grp_load(g) : 5'd0;
        if (bus.is_i_valid && bus.is_o_ready)
          push_pair(bus.is_i_instr_1, bus.is_i_instr_2, bus.is_i_pc_1);
      end
    end
  end

  // ---- stimulus ----
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic er, input logic fl);
    @(posedge clk);
    #1;
    bus.is_i_valid    = v;
    bus.is_i_instr_1  = a;
    bus.is_i_instr_2  = b;
    bus.is_i_pc_1     = pc;
    bus.is_i_ex_ready = er;
    bus.is_i_flush    = fl;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rt_op(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    case ($urandom_range(0, 11))
      0: op = 6'd0;   1: op = 6'd0;   2: op = 6'd8;   3: op = 6'd12;
      4: op = 6'd35;  5: op = 6'd32;  6: op = 6'd43;  7: op = 6'd40;
      8: op = 6'd4;   9: op = 6'd5;   10: op = 6'd2;  default: op = 6'd63;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  initial begin
    bus.is_i_valid    = 1'b0;
    bus.is_i_instr_1  = '0;
    bus.is_i_instr_2  = '0;
    bus.is_i_pc_1     = '0;
    bus.is_i_ex_ready = 1'b1;
    bus.is_i_flush    = 1'b0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({bus.is_o_valid_1, bus.is_o_valid_2, bus.is_o_ready, bus.is_o_split, bus.is_o_dual_cnt}), 64'd0);
    chk("rst_data", 64'(bus.is_o_instr_1 | bus.is_o_instr_2 | bus.is_o_pc_1 | bus.is_o_pc_2), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.is_o_ready), 64'd1);
    chk("post_rst_valid", 64'({bus.is_o_valid_1, bus.is_o_valid_2, bus.is_o_split}), 64'd0);

    // independent pair at pc 0
    drive(1'b1, rt_op(1, 2, 3, 6'h20), rt_op(4, 5, 6, 6'h20), 32'd0, 1'b1, 1'b0);
    idle(3);
    // RAW pair
    drive(1'b1, rt_op(1, 2, 3, 6'h20), rt_op(4, 1, 5, 6'h22), 32'h100, 1'b1, 1'b0);
    idle(4);
    // two loads, then a pair reading the second load's target
    drive(1'b1, i_op(6'd35, 1, 2, 0), i_op(6'd35, 3, 2, 4), 32'h200, 1'b1, 1'b0);
    drive(1'b1, rt_op(5, 3, 0, 6'h20), rt_op(6, 2, 2, 6'h20), 32'h208, 1'b1, 1'b0);
    drive(1'b1, rt_op(5, 3, 0, 6'h20), rt_op(6, 2, 2, 6'h20), 32'h208, 1'b1, 1'b0);
    idle(4);
    // backend stall for three cycles
    drive(1'b1, rt_op(7, 8, 9, 6'h20), rt_op(10, 11, 12, 6'h20), 32'h300, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(3);
    // flush while the second half of a split pair is offered
    drive(1'b1, rt_op(1, 2, 3, 6'h20), rt_op(4, 1, 5, 6'h22), 32'h400, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, rt_op(13, 14, 15, 6'h20), rt_op(16, 17, 18, 6'h20), 32'h500, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_valid", 64'({bus.is_o_valid_1, bus.is_o_valid_2}), 64'd0);
    idle(3);

    // random traffic
    for (int n = 0; n < 600; n++)
      drive(1'b1 && ($urandom_range(0, 3) != 0), rnd_instr(), rnd_instr(),
            32'($urandom) & ~32'h3, $urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0);
    idle(8);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    // asynchronous reset mid-operation
    drive(1'b1, rt_op(1, 2, 3, 6'h20), rt_op(4, 5, 6, 6'h20), 32'h600, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({bus.is_o_valid_1, bus.is_o_valid_2, bus.is_o_ready, bus.is_o_split}), 64'd0);
    chk("async_rst_cnt", 64'(bus.is_o_dual_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
